// File: rtl/jtframe_obj_linesched.sv
// jtframe_obj_linesched: per-line object scheduler that scans the object table on each LHBL fall
// and writes the visible 4bpp pixels into the line buffer. Define JTFRAME_OBJSCHED_HFLIP_EN for hflip.
module jtframe_obj_linesched #(
  parameter int OBJW  = 7,
  parameter int AW    = 9,
  parameter int LIMIT = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            LHBL,
  input  logic [8:0]      vrender,
  output logic [OBJW+1:0] obj_addr,
  input  logic [15:0]     obj_data,
  output logic [19:0]     rom_addr,
  output logic            rom_half,
  output logic            rom_cs,
  input  logic            rom_ok,
  input  logic [31:0]     rom_data,
  output logic [AW-1:0]   buf_addr,
  output logic [7:0]      buf_data,
  output logic            buf_we,
  output logic            busy,
  output logic            overrun
);
  localparam int              DW        = $clog2(LIMIT + 1);
  localparam logic [OBJW-1:0] LAST_IDX  = '1;
  localparam logic [DW-1:0]   LIMIT_CNT = DW'(LIMIT);

  typedef enum logic [2:0] {IDLE, SCAN, CHECK, FETCH, DRAW, NEXT, DONE} state_t;
  state_t state, state_nxt;

  logic            last_lhbl, start;
  logic [8:0]      vr, obj_y, row;
  logic [AW-1:0]   obj_x;
  logic [15:0]     obj_code;
  logic [3:0]      obj_pal, row_q, pix, col;
  logic            obj_en, flip, match, last_obj, limit_hit;
  logic [2:0]      cnt, nib;
  logic [OBJW-1:0] idx;
  logic [DW-1:0]   drawn;
  logic            half, second;
  logic [31:0]     pix_word;

`ifdef JTFRAME_OBJSCHED_HFLIP_EN
  logic obj_flip;
  assign flip = obj_flip;
`else
  assign flip = 1'b0;
`endif

  assign start     = !LHBL && last_lhbl;
  assign row       = vr - obj_y;
  assign match     = obj_en && (row < 9'd16);
  assign last_obj  = idx == LAST_IDX;
  assign limit_hit = drawn == LIMIT_CNT;
  // A mirrored object reads nibbles backwards and starts on the right half, so columns stay ascending.
  assign nib       = flip ? ~cnt : cnt;
  assign pix       = pix_word[{nib, 2'b00} +: 4];
  assign col       = {half ^ flip, cnt};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    state_nxt = state;
    obj_addr  = '0;
    rom_addr  = '0;
    rom_half  = 1'b0;
    rom_cs    = 1'b0;
    buf_addr  = '0;
    buf_data  = '0;
    buf_we    = 1'b0;
    busy      = (state != IDLE) && (state != DONE);
    case (state)
      IDLE, DONE: if (start) state_nxt = SCAN;
      SCAN: begin
        obj_addr = {idx, cnt[1:0]};
        if (cnt == 3'd4) state_nxt = CHECK;
      end
      CHECK: state_nxt = match ? FETCH : NEXT;
      FETCH: begin
        rom_cs   = 1'b1;
        rom_addr = {obj_code, row_q};
        rom_half = half;
        if (rom_ok) state_nxt = DRAW;
      end
      DRAW: begin
        buf_addr = obj_x + AW'(col);
        buf_data = {obj_pal, pix};
        buf_we   = pix != 4'd0;
        if (cnt == 3'd7) state_nxt = second ? NEXT : FETCH;
      end
      NEXT:    state_nxt = (last_obj || limit_hit) ? DONE : SCAN;
      default: state_nxt = IDLE;
    endcase
    // A new line always wins, whatever the scan was doing.
    if (start) state_nxt = SCAN;
  end

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_lhbl <= 1'b0;
      vr        <= '0;
      obj_y     <= '0;
      obj_x     <= '0;
      obj_code  <= '0;
      obj_pal   <= '0;
      obj_en    <= 1'b0;
`ifdef JTFRAME_OBJSCHED_HFLIP_EN
      obj_flip  <= 1'b0;
`endif
      row_q     <= '0;
      cnt       <= '0;
      idx       <= '0;
      drawn     <= '0;
      half      <= 1'b0;
      second    <= 1'b0;
      pix_word  <= '0;
      overrun   <= 1'b0;
    end else begin
      last_lhbl <= LHBL;
      if (start) begin
        vr      <= vrender;
        idx     <= '0;
        drawn   <= '0;
        cnt     <= '0;
        overrun <= (state != IDLE) && (state != DONE);
      end else begin
        case (state)
          SCAN: begin
            cnt <= (cnt == 3'd4) ? 3'd0 : cnt + 3'd1;
            // Table data trails the address by one clock, so word n lands when cnt is n+1.
            case (cnt)
              3'd1: obj_y    <= obj_data[8:0];
              3'd2: obj_x    <= AW'(obj_data[8:0]);
              3'd3: obj_code <= obj_data;
              3'd4: begin
                obj_pal  <= obj_data[3:0];
                obj_en   <= obj_data[15];
`ifdef JTFRAME_OBJSCHED_HFLIP_EN
                obj_flip <= obj_data[4];
`endif
              end
              default: ;
            endcase
          end
          CHECK: begin
            row_q  <= row[3:0];
            half   <= flip;
            second <= 1'b0;
          end
          FETCH: if (rom_ok) pix_word <= rom_data;
          DRAW: begin
            cnt <= cnt + 3'd1;
            if (cnt == 3'd7) begin
              if (!second) begin
                half   <= ~half;
                second <= 1'b1;
              end else begin
                drawn <= drawn + DW'(1);
              end
            end
          end
          NEXT: begin
            if (!last_obj && !limit_hit) idx <= idx + OBJW'(1);
            else if (limit_hit && !last_obj) overrun <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_jtframe_obj_linesched.sv
// Self-checking bench for jtframe_obj_linesched: random object tables checked against a
// column-based reference model of each line's expected line-buffer writes.
`timescale 1ns/1ps
module tb_jtframe_obj_linesched;
  localparam int OBJW = 7, AW = 9, LIMIT = 32, NOBJ = 1 << OBJW, LINE_MAX = 10000;
`ifdef JTFRAME_OBJSCHED_HFLIP_EN
  localparam bit HFLIP = 1'b1;
`else
  localparam bit HFLIP = 1'b0;
`endif

  logic            clk = 1'b0, rst_n = 1'b0, LHBL = 1'b1;
  logic [8:0]      vrender = '0;
  logic [OBJW+1:0] obj_addr;
  logic [15:0]     obj_data = '0;
  logic [19:0]     rom_addr;
  logic            rom_half, rom_cs, rom_ok = 1'b0;
  logic [31:0]     rom_data = '0;
  logic [AW-1:0]   buf_addr;
  logic [7:0]      buf_data;
  logic            buf_we, busy, overrun;

  int          n_checks = 0, n_fail = 0;
  logic [15:0] mem [NOBJ*4];
  logic [OBJW+1:0] addr_q = '0;
  logic        rom_stall = 1'b0, rom_fixed = 1'b0;
  int          rom_wait = 0;
  logic [16:0] got[$], exp_q[$];
  logic        rom_seen = 1'b0, first_half = 1'b0;
  logic [19:0] first_rom = '0;

  jtframe_obj_linesched #(.OBJW(OBJW), .AW(AW), .LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n), .LHBL(LHBL), .vrender(vrender),
    .obj_addr(obj_addr), .obj_data(obj_data),
    .rom_addr(rom_addr), .rom_half(rom_half), .rom_cs(rom_cs), .rom_ok(rom_ok), .rom_data(rom_data),
    .buf_addr(buf_addr), .buf_data(buf_data), .buf_we(buf_we),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] rom_fn(input logic [19:0] a, input logic h);
    logic [31:0] w;
    if (rom_fixed) return 32'h8765_4321;
    w = ({12'd0, a} * 32'h9E37_79B1) ^ (h ? 32'hC3A5_0F1E : 32'h1B87_3D29);
    if (a[1]) w = w & 32'hF0F0_FF0F;
    return w;
  endfunction

  // Object table with one clock of read latency.
  initial forever begin
    @(negedge clk);
    obj_data = mem[addr_q];
    addr_q   = obj_addr;
  end

  // ROM responder with random latency, plus stray rom_ok pulses while idle.
  initial forever begin
    @(negedge clk);
    if (rom_ok) rom_ok = 1'b0;
    else if (rom_cs && !rom_stall) begin
      if (rom_wait == 0) begin
        rom_ok   = 1'b1;
        rom_data = rom_fn(rom_addr, rom_half);
        rom_wait = $urandom_range(0, 3);
      end else rom_wait--;
    end else if (!rom_cs && $urandom_range(0, 15) == 0) begin
      rom_ok   = 1'b1;
      rom_data = $urandom;
    end
  end

  initial forever begin
    @(negedge clk);
    if (buf_we) got.push_back({buf_addr, buf_data});
    if (rom_cs && !rom_seen) begin
      rom_seen   = 1'b1;
      first_rom  = rom_addr;
      first_half = rom_half;
    end
  end

  task automatic clear_table();
    for (int i = 0; i < NOBJ*4; i++) mem[i] = '0;
  endtask

  task automatic set_obj(input int i, input logic [8:0] y, input logic [8:0] x, input logic [15:0] code,
                         input logic [3:0] pal, input logic fl, input logic en);
    mem[4*i]   = {7'd0, y};
    mem[4*i+1] = {7'd0, x};
    mem[4*i+2] = code;
    mem[4*i+3] = {en, 10'd0, fl, pal};
  endtask

  // Expected writes: each visible object paints columns 0..15 left to right, skipping pixel 0.
  task automatic build_model(input logic [8:0] v, output logic exp_ovr);
    int n;
    n = 0;
    exp_ovr = 1'b0;
    exp_q.delete();
    for (int i = 0; i < NOBJ; i++) begin
      logic [15:0] w0, w1, w2, w3;
      int row;
      bit fl;
      if (n == LIMIT) begin
        exp_ovr = 1'b1;
        break;
      end
      w0 = mem[4*i]; w1 = mem[4*i+1]; w2 = mem[4*i+2]; w3 = mem[4*i+3];
      row = (int'(v) - int'(w0[8:0]) + 512) % 512;
      if (!w3[15] || row >= 16) continue;
      fl = HFLIP && w3[4];
      for (int c = 0; c < 16; c++) begin
        int h, j;
        logic [31:0] word;
        logic [3:0] p;
        if (!fl) begin h = c / 8; j = c % 8; end
        else begin h = (c < 8) ? 1 : 0; j = 7 - (c % 8); end
        word = rom_fn({w2, 4'(row)}, h[0]);
        p = word[4*j +: 4];
        if (p != 4'd0) exp_q.push_back({9'((int'(w1[8:0]) + c) % 512), w3[3:0], p});
      end
      n++;
    end
  endtask

  task automatic wait_idle();
    int cyc;
    cyc = 0;
    while (busy && cyc < LINE_MAX) begin
      @(negedge clk);
      cyc++;
    end
    check("busy_fall", busy, 0);
  endtask

  task automatic compare(input logic eo);
    check("n_writes", got.size(), exp_q.size());
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      check($sformatf("wr%0d", i), got[i], exp_q[i]);
    check("overrun", overrun, eo);
  endtask

  task automatic run_line(input logic [8:0] v);
    logic eo;
    build_model(v, eo);
    got.delete();
    rom_seen = 1'b0;
    @(negedge clk);
    vrender = v;
    LHBL = 1'b0;
    @(negedge clk);
    check("busy_rise", busy, 1);
    vrender = 9'($urandom);
    wait_idle();
    compare(eo);
    LHBL = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic eo;
    logic [16:0] g;
    int cyc;
    clear_table();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    check("rst_rom_cs", rom_cs, 0);
    check("rst_buf_we", buf_we, 0);
    check("rst_obj_addr", obj_addr, 0);
    check("rst_rom_addr", rom_addr, 0);
    check("rst_buf_addr", buf_addr, 0);

    // Single object, row 2.
    set_obj(0, 9'd10, 9'd100, 16'd5, 4'h3, 1'b0, 1'b1);
    run_line(9'd12);
    check("first_rom_addr", first_rom, {16'd5, 4'd2});
    check("first_rom_half", first_half, 0);

    // Row wrap: far below the line is invisible, just above the wrap point is visible.
    clear_table();
    set_obj(0, 9'd300, 9'd0, 16'h0042, 4'h1, 1'b0, 1'b1);
    run_line(9'd2);
    check("wrap_nodraw", got.size(), 0);
    set_obj(0, 9'd510, 9'd40, 16'h0ABC, 4'h2, 1'b0, 1'b1);
    run_line(9'd4);
    check("wrap_row6", first_rom[3:0], 6);

    // Horizontal wrap with all pixels opaque.
    rom_fixed = 1'b1;
    clear_table();
    set_obj(0, 9'd20, 9'd505, 16'h0777, 4'h5, 1'b0, 1'b1);
    run_line(9'd25);
    check("xwrap_count", got.size(), 16);
    if (got.size() == 16) begin
      g = got[15];
      check("xwrap_last", g[16:8], 8);
    end

    // More matches than the limit.
    clear_table();
    for (int i = 0; i < LIMIT + 3; i++)
      set_obj(i, 9'd97, 9'($urandom), 16'($urandom), 4'($urandom), 1'($urandom), 1'b1);
    run_line(9'd100);
    check("limit_slots", got.size(), LIMIT * 16);
    check("limit_ovr", overrun, 1);

`ifdef JTFRAME_OBJSCHED_HFLIP_EN
    clear_table();
    set_obj(0, 9'd0, 9'd200, 16'd7, 4'h9, 1'b1, 1'b1);
    run_line(9'd0);
    if (got.size() == 16) begin
      check("flip_col0", got[0], {9'd200, 4'h9, 4'h8});
      check("flip_col8", got[8], {9'd208, 4'h9, 4'h8});
    end else check("flip_count", got.size(), 16);
`endif
    rom_fixed = 1'b0;

    // New line while a ROM request is outstanding.
    clear_table();
    set_obj(0, 9'd50, 9'd20, 16'h1234, 4'h6, 1'b0, 1'b1);
    rom_stall = 1'b1;
    @(negedge clk);
    vrender = 9'd55;
    LHBL = 1'b0;
    cyc = 0;
    while (!rom_cs && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("abort_fetch", rom_cs, 1);
    repeat (3) @(negedge clk);
    LHBL = 1'b1;
    @(negedge clk);
    build_model(9'd57, eo);
    got.delete();
    LHBL = 1'b0;
    vrender = 9'd57;
    @(negedge clk);
    check("abort_cs", rom_cs, 0);
    check("abort_ovr", overrun, 1);
    check("abort_busy", busy, 1);
    check("abort_idx", obj_addr, 0);
    rom_stall = 1'b0;
    wait_idle();
    compare(1'b1);
    LHBL = 1'b1;
    repeat (2) @(negedge clk);

    // Random tables.
    for (int t = 0; t < 8; t++) begin
      logic [8:0] v, y;
      v = 9'($urandom);
      clear_table();
      for (int i = 0; i < NOBJ; i++) begin
        y = ($urandom_range(0, 1) == 1) ? 9'(v - 9'($urandom_range(0, 20))) : 9'($urandom);
        set_obj(i, y, 9'($urandom), 16'($urandom), 4'($urandom), 1'($urandom), $urandom_range(0, 2) == 0);
      end
      run_line(v);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
